// File: rtl/ps2_host_rx.sv
// Host-side PS/2 receiver: synchronises and filters the device lines, deframes
// 11-bit frames and folds E0/F0 prefixes into flags on the following scan code.
module ps2_host_rx #(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned FILTER_LEN   = 4,
   parameter logic [31:0] TIMEOUT      = 32'd100000,
   parameter bit          CHECK_PARITY = 1'b1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_ps2_clk,
   input  logic       i_ps2_data,
   output logic [7:0] o_code,
   output logic       o_ext,
   output logic       o_break,
   output logic       o_valid,
   output logic       o_err,
   output logic       o_busy
);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic [FILTER_LEN-1:0]  filt_sr;
   logic                   filt_q;
   logic                   fall;
   logic                   data_s;

   state_t      state_q, state_nxt;
   logic [2:0]  bit_cnt_q, bit_cnt_nxt;
   logic [7:0]  shift_q, shift_nxt;
   logic        par_q, par_nxt;
   logic        ext_f_q, ext_f_nxt;
   logic        brk_f_q, brk_f_nxt;
   logic [31:0] to_cnt_q, to_cnt_nxt;
   logic [7:0]  code_nxt;
   logic        ext_nxt, brk_nxt, valid_nxt, err_nxt;
   logic        frame_good;
   logic        timeout_hit;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         clk_sync  <= '1;
         data_sync <= '1;
         filt_sr   <= '1;
         filt_q    <= 1'b1;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], i_ps2_data};
         filt_sr   <= {filt_sr[FILTER_LEN-2:0], clk_sync[SYNC_STAGES-1]};
         if (filt_sr == '1)
            filt_q <= 1'b1;
         else if (filt_sr == '0)
            filt_q <= 1'b0;
      end
   end

   // Strobe coincides with the cycle the filtered level drops, so data is sampled in step.
   assign fall   = filt_q & (filt_sr == '0);
   assign data_s = data_sync[SYNC_STAGES-1];

   assign frame_good  = data_s && (!CHECK_PARITY || (^{shift_q, par_q}));
   assign timeout_hit = (state_q != IDLE) && (to_cnt_q == TIMEOUT - 32'd1);

   always_comb begin
      state_nxt   = state_q;
      bit_cnt_nxt = bit_cnt_q;
      shift_nxt   = shift_q;
      par_nxt     = par_q;
      ext_f_nxt   = ext_f_q;
      brk_f_nxt   = brk_f_q;
      code_nxt    = o_code;
      ext_nxt     = o_ext;
      brk_nxt     = o_break;
      valid_nxt   = 1'b0;
      err_nxt     = 1'b0;
      to_cnt_nxt  = (state_q == IDLE || fall) ? '0 : to_cnt_q + 32'd1;

      if (fall) begin
         unique case (state_q)
            IDLE: begin
               if (!data_s) begin
                  state_nxt   = DATA;
                  bit_cnt_nxt = '0;
               end
            end
            DATA: begin
               shift_nxt   = {data_s, shift_q[7:1]};
               bit_cnt_nxt = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7)
                  state_nxt = PARITY;
            end
            PARITY: begin
               par_nxt   = data_s;
               state_nxt = STOP;
            end
            STOP: begin
               state_nxt = IDLE;
               if (!frame_good) begin
                  err_nxt   = 1'b1;
                  ext_f_nxt = 1'b0;
                  brk_f_nxt = 1'b0;
               end else if (shift_q == 8'hE0) begin
                  ext_f_nxt = 1'b1;
               end else if (shift_q == 8'hF0) begin
                  brk_f_nxt = 1'b1;
               end else begin
                  code_nxt  = shift_q;
                  ext_nxt   = ext_f_q;
                  brk_nxt   = brk_f_q;
                  valid_nxt = 1'b1;
                  ext_f_nxt = 1'b0;
                  brk_f_nxt = 1'b0;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end else if (timeout_hit) begin
         state_nxt  = IDLE;
         err_nxt    = 1'b1;
         ext_f_nxt  = 1'b0;
         brk_f_nxt  = 1'b0;
         to_cnt_nxt = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         ext_f_q   <= 1'b0;
         brk_f_q   <= 1'b0;
         to_cnt_q  <= '0;
         o_code    <= '0;
         o_ext     <= 1'b0;
         o_break   <= 1'b0;
         o_valid   <= 1'b0;
         o_err     <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         bit_cnt_q <= bit_cnt_nxt;
         shift_q   <= shift_nxt;
         par_q     <= par_nxt;
         ext_f_q   <= ext_f_nxt;
         brk_f_q   <= brk_f_nxt;
         to_cnt_q  <= to_cnt_nxt;
         o_code    <= code_nxt;
         o_ext     <= ext_nxt;
         o_break   <= brk_nxt;
         o_valid   <= valid_nxt;
         o_err     <= err_nxt;
      end
   end

   assign o_busy = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_host_rx.sv
// Bench for ps2_host_rx: two instances (parity enforced / ignored) share the PS/2
// lines; results are scored against a frame-level model and a directed table.
module tb_ps2_host_rx;

   localparam int unsigned TO   = 400;
   localparam int unsigned HALF = 50;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;

   logic [7:0] code0, code1;
   logic       ext0, ext1, brk0, brk1, valid0, valid1, err0, err1, busy0, busy1;

   ps2_host_rx #(.SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT(32'd400), .CHECK_PARITY(1'b1)) dut (
      .i_clk(clk), .i_rst(rst), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
      .o_code(code0), .o_ext(ext0), .o_break(brk0), .o_valid(valid0), .o_err(err0), .o_busy(busy0)
   );

   ps2_host_rx #(.SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT(32'd400), .CHECK_PARITY(1'b0)) dut_np (
      .i_clk(clk), .i_rst(rst), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
      .o_code(code1), .o_ext(ext1), .o_break(brk1), .o_valid(valid1), .o_err(err1), .o_busy(busy1)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int         vcnt[2];
   int         ecnt[2];
   logic [7:0] lcode[2];
   logic       lext[2];
   logic       lbrk[2];
   bit         m_ext[2];
   bit         m_brk[2];

   always @(negedge clk) begin
      if (valid0) begin vcnt[0]++; lcode[0] = code0; lext[0] = ext0; lbrk[0] = brk0; end
      if (err0) ecnt[0]++;
      if (valid1) begin vcnt[1]++; lcode[1] = code1; lext[1] = ext1; lbrk[1] = brk1; end
      if (err1) ecnt[1]++;
   end

   typedef struct {
      logic [7:0] data;
      bit         pb;
      bit         sb;
      bit         ev;
      bit         ee;
      logic [7:0] ec;
      bit         ex;
      bit         eb;
   } vec_t;

   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input bit d);
      ps2_data = d;
      wait_cyc(HALF / 2);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
      wait_cyc(HALF / 2);
   endtask

   // Frame-level rules: odd parity over data+parity, stop must be 1, prefixes become flags.
   task automatic model_frame(input int k, input logic [7:0] b, input bit par, input bit stop,
                              output bit ev, output bit ee, output logic [7:0] ec,
                              output bit ex, output bit eb);
      bit good;
      good = stop && (k == 1 || ((($countones(b) + int'(par)) % 2) == 1));
      ev = 0; ee = 0; ec = '0; ex = 0; eb = 0;
      if (!good) begin
         ee = 1; m_ext[k] = 0; m_brk[k] = 0;
      end else if (b == 8'hE0) begin
         m_ext[k] = 1;
      end else if (b == 8'hF0) begin
         m_brk[k] = 1;
      end else begin
         ev = 1; ec = b; ex = m_ext[k]; eb = m_brk[k];
         m_ext[k] = 0; m_brk[k] = 0;
      end
   endtask

   task automatic run_frame(input logic [7:0] b, input bit pb, input bit sb,
                            output int av, output int ae, output logic [7:0] ac,
                            output bit ax, output bit ab);
      int sv[2], se[2];
      bit par;
      bit ev, ee, ex, eb;
      logic [7:0] ec;
      for (int k = 0; k < 2; k++) begin sv[k] = vcnt[k]; se[k] = ecnt[k]; end
      par = (~^b) ^ pb;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(par);
      drive_bit(~sb);
      wait_cyc(20);
      for (int k = 0; k < 2; k++) begin
         model_frame(k, b, par, ~sb, ev, ee, ec, ex, eb);
         chk($sformatf("dut%0d valid count byte %02h", k, b), vcnt[k] - sv[k], ev);
         chk($sformatf("dut%0d err count byte %02h", k, b), ecnt[k] - se[k], ee);
         if (ev) begin
            chk($sformatf("dut%0d code", k), lcode[k], ec);
            chk($sformatf("dut%0d ext", k), lext[k], ex);
            chk($sformatf("dut%0d break", k), lbrk[k], eb);
         end
      end
      chk("busy0 after frame", busy0, 0);
      chk("busy1 after frame", busy1, 0);
      av = vcnt[0] - sv[0]; ae = ecnt[0] - se[0];
      ac = lcode[0]; ax = lext[0]; ab = lbrk[0];
   endtask

   initial begin
      int av, ae, n, s_v0, s_e0, s_v1, s_e1;
      logic [7:0] ac, b;
      bit ax, ab, got, busy_seen;

      tbl[0]  = '{8'h1C, 0, 0, 1, 0, 8'h1C, 0, 0};
      tbl[1]  = '{8'hF0, 0, 0, 0, 0, 8'h00, 0, 0};
      tbl[2]  = '{8'h1C, 0, 0, 1, 0, 8'h1C, 0, 1};
      tbl[3]  = '{8'hE0, 0, 0, 0, 0, 8'h00, 0, 0};
      tbl[4]  = '{8'hF0, 0, 0, 0, 0, 8'h00, 0, 0};
      tbl[5]  = '{8'h75, 0, 0, 1, 0, 8'h75, 1, 1};
      tbl[6]  = '{8'h1C, 1, 0, 0, 1, 8'h00, 0, 0};
      tbl[7]  = '{8'h1C, 0, 0, 1, 0, 8'h1C, 0, 0};
      tbl[8]  = '{8'hF0, 0, 1, 0, 1, 8'h00, 0, 0};
      tbl[9]  = '{8'h5A, 0, 0, 1, 0, 8'h5A, 0, 0};
      tbl[10] = '{8'hF0, 1, 0, 0, 1, 8'h00, 0, 0};  // emulator F0 with parity forced 0
      tbl[11] = '{8'h3E, 0, 0, 1, 0, 8'h3E, 0, 0};  // forced 0 is the correct parity for 3E

      wait_cyc(5);
      chk("reset code", code0, 0);
      chk("reset ext", ext0, 0);
      chk("reset break", brk0, 0);
      chk("reset valid", valid0, 0);
      chk("reset err", err0, 0);
      chk("reset busy", busy0, 0);
      rst = 1'b0;
      wait_cyc(20);

      for (int i = 0; i < 12; i++) begin
         run_frame(tbl[i].data, tbl[i].pb, tbl[i].sb, av, ae, ac, ax, ab);
         chk($sformatf("tbl%0d valid", i), av, tbl[i].ev);
         chk($sformatf("tbl%0d err", i), ae, tbl[i].ee);
         if (tbl[i].ev) begin
            chk($sformatf("tbl%0d code", i), ac, tbl[i].ec);
            chk($sformatf("tbl%0d ext", i), ax, tbl[i].ex);
            chk($sformatf("tbl%0d break", i), ab, tbl[i].eb);
         end
      end

      // Short low glitch on the clock while idle must not start a frame.
      s_v0 = vcnt[0]; s_e0 = ecnt[0];
      ps2_clk = 1'b0;
      wait_cyc(2);
      ps2_clk = 1'b1;
      busy_seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy0) busy_seen = 1;
      end
      chk("glitch busy", busy_seen, 0);
      chk("glitch pulses", (vcnt[0] - s_v0) + (ecnt[0] - s_e0), 0);

      // Reset mid-frame after a prefix: partial frame and flag dropped silently.
      run_frame(8'hE0, 0, 0, av, ae, ac, ax, ab);
      s_v0 = vcnt[0]; s_e0 = ecnt[0]; s_v1 = vcnt[1]; s_e1 = ecnt[1];
      drive_bit(1'b0);
      for (int i = 0; i < 5; i++) drive_bit(1'b1);
      chk("busy before reset", busy0, 1);
      rst = 1'b1;
      wait_cyc(1);
      rst = 1'b0;
      chk("busy after reset", busy0, 0);
      wait_cyc(20);
      chk("reset pulses dut0", (vcnt[0] - s_v0) + (ecnt[0] - s_e0), 0);
      chk("reset pulses dut1", (vcnt[1] - s_v1) + (ecnt[1] - s_e1), 0);
      for (int k = 0; k < 2; k++) begin m_ext[k] = 0; m_brk[k] = 0; end
      run_frame(8'hF0, 0, 0, av, ae, ac, ax, ab);
      run_frame(8'h1C, 0, 0, av, ae, ac, ax, ab);
      chk("post-reset break", ab, 1);
      chk("post-reset ext", ax, 0);

      // Timeout: start + 4 data bits, then the clock stays high.
      run_frame(8'hF0, 0, 0, av, ae, ac, ax, ab);
      s_v0 = vcnt[0]; s_e0 = ecnt[0]; s_v1 = vcnt[1]; s_e1 = ecnt[1];
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(1'b1);
      ps2_data = 1'b0;
      wait_cyc(HALF / 2);
      ps2_clk = 1'b0;
      n = 0;
      got = 0;
      while (n < int'(TO) + 100 && !got) begin
         @(negedge clk);
         n++;
         if (n == int'(HALF)) ps2_clk = 1'b1;
         if (err0) got = 1;
      end
      chk("timeout seen", got, 1);
      chk("timeout window", (n >= int'(TO) && n <= int'(TO) + 12), 1);
      wait_cyc(5);
      chk("timeout busy", busy0, 0);
      chk("timeout err dut0", ecnt[0] - s_e0, 1);
      chk("timeout err dut1", ecnt[1] - s_e1, 1);
      chk("timeout valid dut0", vcnt[0] - s_v0, 0);
      for (int k = 0; k < 2; k++) begin m_ext[k] = 0; m_brk[k] = 0; end
      run_frame(8'h29, 0, 0, av, ae, ac, ax, ab);
      chk("after timeout code", ac, 8'h29);
      chk("after timeout break", ab, 0);

      // Randomised frames against the model.
      for (int i = 0; i < 24; i++) begin
         n = int'($urandom_range(0, 9));
         if (n == 0) b = 8'hE0;
         else if (n == 1) b = 8'hF0;
         else b = 8'($urandom);
         run_frame(b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0), av, ae, ac, ax, ab);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
